// File: rtl/arb_pkg.sv
// Shared defaults and helpers for the weighted round-robin arbiter.
package arb_pkg;

  localparam int unsigned DefN  = 4;
  localparam int unsigned DefWW = 4;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_safe(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Low bit of requester idx's weight field in the packed WEIGHT vector.
  function automatic int unsigned wslice_lo(input int unsigned idx, input int unsigned ww);
    return idx * ww;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select: rotate req by ptr, priority-encode, un-rotate.
module rr_pick
  import arb_pkg::*;
#(
  parameter int unsigned N = DefN,
  localparam int unsigned IW = clog2_safe(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] win_id,
  output logic          win_vld
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [IW-1:0]  w_off;
  logic [IW:0]    w_sum;

  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[N-1:0];

  // Descending scan so the lowest rotated position (closest to ptr) wins.
  always_comb begin
    w_off   = '0;
    win_vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off   = IW'(i);
        win_vld = 1'b1;
      end
    end
  end

  assign w_sum  = {1'b0, w_off} + {1'b0, ptr};
  assign win_id = (w_sum >= (IW + 1)'(N)) ? IW'(w_sum - (IW + 1)'(N)) : w_sum[IW-1:0];

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with per-requester quantum and lock-to-hold.
module wrr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N  = DefN,
  parameter int unsigned WW = DefWW,
  parameter int unsigned IW = clog2_safe(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    REQ,
  input  logic [N*WW-1:0] WEIGHT,
  input  logic [N-1:0]    LOCK,
  output logic [N-1:0]    GNT,
  output logic [IW-1:0]   GNT_ID,
  output logic            GNT_VLD
);

  logic [IW-1:0] r_owner;
  logic          r_own_vld;
  logic [WW-1:0] r_credit;
  logic [IW-1:0] r_ptr;

  logic [IW-1:0] w_win_id;
  logic          w_win_vld;
  logic          w_hold;
  logic [WW-1:0] w_win_wt;

  rr_pick #(
    .N (N)
  ) u_pick (
    .req     (REQ),
    .ptr     (r_ptr),
    .win_id  (w_win_id),
    .win_vld (w_win_vld)
  );

  assign w_hold   = r_own_vld && REQ[r_owner] && ((r_credit > WW'(1)) || LOCK[r_owner]);
  assign w_win_wt = WEIGHT[wslice_lo(32'(w_win_id), WW) +: WW];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner   <= '0;
      r_own_vld <= 1'b0;
      r_credit  <= '0;
      r_ptr     <= '0;
    end else if (w_hold) begin
      // A locked owner past expiry parks at credit 1.
      if (r_credit > WW'(1)) r_credit <= r_credit - WW'(1);
    end else if (w_win_vld) begin
      r_owner   <= w_win_id;
      r_own_vld <= 1'b1;
      r_credit  <= (w_win_wt == '0) ? WW'(1) : w_win_wt;
      r_ptr     <= (w_win_id == IW'(N - 1)) ? '0 : w_win_id + IW'(1);
    end else begin
      r_own_vld <= 1'b0;
    end
  end

  always_comb begin
    GNT = '0;
    if (r_own_vld) GNT[r_owner] = 1'b1;
  end

  assign GNT_ID  = r_owner;
  assign GNT_VLD = r_own_vld;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: directed steps plus random traffic vs a reference model.
module tb_wrr_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  REQ;
  logic [N*WW-1:0] WEIGHT;
  logic [N-1:0]  LOCK;
  logic [N-1:0]  GNT;
  logic [1:0]    GNT_ID;
  logic          GNT_VLD;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_owner  = 0;
  bit m_vld    = 0;
  int m_credit = 0;
  int m_ptr    = 0;

  wrr_arbiter #(
    .N  (N),
    .WW (WW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .REQ     (REQ),
    .WEIGHT  (WEIGHT),
    .LOCK    (LOCK),
    .GNT     (GNT),
    .GNT_ID  (GNT_ID),
    .GNT_VLD (GNT_VLD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the arbitration rules, in plain integer terms.
  task automatic model_edge(input logic [N-1:0] rq, input logic [N*WW-1:0] wt,
                            input logic [N-1:0] lk, input logic r);
    int w;
    int q;
    bit found;
    if (r) begin
      m_vld = 0; m_owner = 0; m_credit = 0; m_ptr = 0;
      return;
    end
    if (m_vld && rq[m_owner] && (m_credit > 1 || lk[m_owner])) begin
      if (m_credit > 1) m_credit = m_credit - 1;
      return;
    end
    found = 0;
    w = 0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (!found && rq[c]) begin
        found = 1;
        w = c;
      end
    end
    if (found) begin
      q = int'(wt[w*WW +: WW]);
      m_owner  = w;
      m_vld    = 1;
      m_credit = (q == 0) ? 1 : q;
      m_ptr    = (w + 1) % N;
    end else begin
      m_vld = 0;
    end
  endtask

  task automatic step(input logic [N-1:0] rq, input logic [N*WW-1:0] wt,
                      input logic [N-1:0] lk, input logic r);
    logic [N-1:0] exp_gnt;
    REQ = rq; WEIGHT = wt; LOCK = lk; rst = r;
    @(posedge clk);
    model_edge(rq, wt, lk, r);
    #1;
    exp_gnt = m_vld ? (N'(1) << m_owner) : '0;
    chk("model_gnt", 32'(GNT), 32'(exp_gnt));
    chk("model_vld", 32'(GNT_VLD), 32'(m_vld));
    if (m_vld || r) chk("model_id", 32'(GNT_ID), 32'(m_owner));
  endtask

  logic [N-1:0]    rq;
  logic [N*WW-1:0] wt;
  logic [N-1:0]    lk;
  logic [N-1:0]    seq3 [7];
  bit              seen;

  initial begin
    REQ = '0; WEIGHT = '0; LOCK = '0; rst = 1'b1;

    // 1: reset, idle, mid-grant reset
    step(4'b0000, 16'h1111, 4'b0000, 1'b1);
    chk("rst_gnt", 32'(GNT), 32'h0);
    chk("rst_id", 32'(GNT_ID), 32'h0);
    chk("rst_vld", 32'(GNT_VLD), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 16'h1111, 4'b0000, 1'b0);
      chk("idle_gnt", 32'(GNT), 32'h0);
    end
    step(4'b0100, 16'h0500, 4'b0000, 1'b0);
    step(4'b0100, 16'h0500, 4'b0000, 1'b0);
    chk("pre_rst_gnt", 32'(GNT), 32'h4);
    step(4'b0100, 16'h0500, 4'b0000, 1'b1);
    chk("mid_rst_gnt", 32'(GNT), 32'h0);
    chk("mid_rst_vld", 32'(GNT_VLD), 32'h0);
    step(4'b1111, 16'h1111, 4'b0000, 1'b0);
    chk("ptr_after_rst", 32'(GNT), 32'h1);

    // 2: unit weights, everyone requesting
    step(4'b0000, 16'h1111, 4'b0000, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, 16'h1111, 4'b0000, 1'b0);
      chk("rr_unit", 32'(GNT), 32'(4'b0001 << (i % 4)));
    end

    // 3: weights {1,1,2,3} for req3..req0
    seq3[0] = 4'b0001; seq3[1] = 4'b0001; seq3[2] = 4'b0001;
    seq3[3] = 4'b0010; seq3[4] = 4'b0010; seq3[5] = 4'b0100; seq3[6] = 4'b1000;
    step(4'b0000, 16'h1123, 4'b0000, 1'b1);
    for (int i = 0; i < 14; i++) begin
      step(4'b1111, 16'h1123, 4'b0000, 1'b0);
      chk("wrr_seq", 32'(GNT), 32'(seq3[i % 7]));
    end

    // 4: sole requester has no bubble, then req1 joins
    step(4'b0000, 16'h0200, 4'b0000, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(4'b0100, 16'h0200, 4'b0000, 1'b0);
      chk("sole_nobubble", 32'(GNT), 32'h4);
    end
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      step(4'b0110, 16'h0200, 4'b0000, 1'b0);
      if (GNT == 4'b0010) seen = 1;
    end
    chk("join_within_2", 32'(seen), 32'h1);

    // 5: lock holds past expiry; weight 0 acts as quantum 1
    step(4'b0000, 16'h0010, 4'b0000, 1'b1);
    step(4'b0011, 16'h0010, 4'b0010, 1'b0);
    chk("w0_first", 32'(GNT), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step(4'b0011, 16'h0010, 4'b0010, 1'b0);
      chk("lock_hold", 32'(GNT), 32'h2);
    end
    step(4'b0011, 16'h0010, 4'b0000, 1'b0);
    chk("unlock_move", 32'(GNT), 32'h1);
    step(4'b0011, 16'h0010, 4'b0000, 1'b0);
    chk("w0_quantum1", 32'(GNT), 32'h2);

    // 6: early drop, then ptr wrap after winner 3
    step(4'b0000, 16'h1511, 4'b0000, 1'b1);
    step(4'b0100, 16'h1511, 4'b0000, 1'b0);
    step(4'b0100, 16'h1511, 4'b0000, 1'b0);
    chk("early_pre", 32'(GNT), 32'h4);
    step(4'b0001, 16'h1511, 4'b0000, 1'b0);
    chk("early_drop", 32'(GNT), 32'h1);
    step(4'b0000, 16'h1111, 4'b0000, 1'b1);
    step(4'b1000, 16'h1111, 4'b0000, 1'b0);
    chk("wrap_w3", 32'(GNT), 32'h8);
    step(4'b0011, 16'h1111, 4'b0000, 1'b0);
    chk("wrap_req0", 32'(GNT), 32'h1);
    chk("wrap_id", 32'(GNT_ID), 32'h0);

    // Random traffic against the model
    rq = 4'b1111; wt = 16'h1234; lk = '0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) rq = N'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) wt = (N*WW)'($urandom);
      lk = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '0;
      step(rq, wt, lk, ($urandom_range(0, 99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
